// File: rtl/rng_entropy_packer_if.sv
// Output word stream of rng_entropy_packer: show-ahead valid/ready bus toward the HPS-side reader.
interface rng_entropy_packer_if;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/rng_entropy_packer.sv
// Combines A/B sample LSBs into raw random bits, optionally debiases them (RNG_VON_NEUMANN_EN),
// packs 32-bit words LSB first and buffers them in a show-ahead FIFO with overflow/overrange status.
module rng_entropy_packer #(
   parameter int FIFO_DEPTH = 16,
   parameter int LVL_W      = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [13:0]           ada_d,
   input  logic                  ada_valid,
   input  logic                  ada_or,
   input  logic [13:0]           adb_d,
   input  logic                  adb_valid,
   input  logic                  adb_or,
   rng_entropy_packer_if.master  stream,
   output logic [LVL_W-1:0]      fifo_level,
   output logic                  overflow,
   input  logic                  clr_overflow,
   output logic [15:0]           or_count
);

   localparam int                AW      = $clog2(FIFO_DEPTH);
   localparam logic [LVL_W-1:0]  DEPTH_L = LVL_W'(FIFO_DEPTH);

   logic              pair_s;
   logic              ovr_s;
   logic              unused_bits_s;
   logic              raw_vld_r;
   logic              raw_bit_r;
   logic [15:0]       or_count_r;

   logic              pk_vld_s;
   logic              pk_bit_s;
   logic [31:0]       word_s;
   logic [31:0]       shreg_r;
   logic [4:0]        bit_cnt_r;
   logic              push_vld_r;
   logic [31:0]       push_word_r;

   logic [31:0]       mem_r [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [LVL_W-1:0]  level_r;
   logic              overflow_r;
   logic              pop_s;
   logic              push_ok_s;

   assign pair_s        = ada_valid && adb_valid;
   assign ovr_s         = ada_or || adb_or;
   // Only the LSBs carry entropy; the upper sample bits are intentionally dropped.
   assign unused_bits_s = ^{ada_d[13:1], adb_d[13:1]};

   // Stage 1: raw bit extraction and saturating overrange-discard counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         raw_vld_r  <= 1'b0;
         raw_bit_r  <= 1'b0;
         or_count_r <= 16'd0;
      end else begin
         raw_vld_r <= pair_s && !ovr_s;
         raw_bit_r <= ada_d[0] ^ adb_d[0];
         if (pair_s && ovr_s && (or_count_r != 16'hFFFF)) begin
            or_count_r <= or_count_r + 16'd1;
         end else begin
            or_count_r <= or_count_r;
         end
      end
   end

`ifdef RNG_VON_NEUMANN_EN
   typedef enum logic {
      IDLE       = 1'b0,
      HAVE_FIRST = 1'b1
   } vn_state_t;

   vn_state_t vn_state_r;
   logic      vn_first_r;
   logic      vn_vld_r;
   logic      vn_bit_r;

   // Stage 2: Von Neumann corrector, emits the first bit of an unequal raw pair.
   always_ff @(posedge clk) begin
      if (reset) begin
         vn_state_r <= IDLE;
         vn_first_r <= 1'b0;
         vn_vld_r   <= 1'b0;
         vn_bit_r   <= 1'b0;
      end else if (raw_vld_r) begin
         case (vn_state_r)
            IDLE: begin
               vn_first_r <= raw_bit_r;
               vn_state_r <= HAVE_FIRST;
               vn_vld_r   <= 1'b0;
            end
            HAVE_FIRST: begin
               vn_state_r <= IDLE;
               vn_vld_r   <= (vn_first_r != raw_bit_r);
               vn_bit_r   <= vn_first_r;
            end
            default: begin
               vn_state_r <= IDLE;
               vn_vld_r   <= 1'b0;
            end
         endcase
      end else begin
         vn_vld_r <= 1'b0;
      end
   end

   assign pk_vld_s = vn_vld_r;
   assign pk_bit_s = vn_bit_r;
`else
   assign pk_vld_s = raw_vld_r;
   assign pk_bit_s = raw_bit_r;
`endif

   // New bits enter at the MSB so the first bit ends up in bit 0 after 32 shifts.
   assign word_s = {pk_bit_s, shreg_r[31:1]};

   // Packer: shift register plus bit counter; a completed word is staged for the FIFO.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg_r     <= 32'd0;
         bit_cnt_r   <= 5'd0;
         push_vld_r  <= 1'b0;
         push_word_r <= 32'd0;
      end else if (pk_vld_s) begin
         shreg_r     <= word_s;
         bit_cnt_r   <= bit_cnt_r + 5'd1;
         push_vld_r  <= (bit_cnt_r == 5'd31);
         push_word_r <= word_s;
      end else begin
         push_vld_r  <= 1'b0;
      end
   end

   assign pop_s     = (level_r != '0) && stream.out_ready;
   assign push_ok_s = push_vld_r && ((level_r < DEPTH_L) || pop_s);

   // FIFO storage; when full with a simultaneous pop, the write lands in the slot being freed.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_word_r;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // FIFO pointers, level and sticky overflow (set has priority over clear).
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         level_r    <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_ok_s, pop_s})
            2'b10:   level_r <= level_r + LVL_W'(1);
            2'b01:   level_r <= level_r - LVL_W'(1);
            default: level_r <= level_r;
         endcase
         if (push_vld_r && !push_ok_s) begin
            overflow_r <= 1'b1;
         end else if (clr_overflow) begin
            overflow_r <= 1'b0;
         end else begin
            overflow_r <= overflow_r;
         end
      end
   end

   assign stream.out_valid = (level_r != '0);
   assign stream.out_data  = (level_r != '0) ? mem_r[rd_ptr_r] : 32'd0;
   assign fifo_level       = level_r;
   assign overflow         = overflow_r;
   assign or_count         = or_count_r;

endmodule

// File: tb/tb_rng_entropy_packer.sv
// Scoreboard bench for rng_entropy_packer: bit-list reference model feeds an expected-word queue,
// a negedge monitor pops and compares every word the DUT hands out.
module tb_rng_entropy_packer;
   localparam int DEPTH = 16;
`ifdef RNG_VON_NEUMANN_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] ada_d, adb_d;
   logic        ada_valid, adb_valid, ada_or, adb_or;
   logic [4:0]  fifo_level;
   logic        overflow;
   logic        clr_overflow;
   logic [15:0] or_count;

   rng_entropy_packer_if sif ();

   rng_entropy_packer #(.FIFO_DEPTH(DEPTH), .LVL_W(5)) dut (
      .clk(clk), .reset(reset),
      .ada_d(ada_d), .ada_valid(ada_valid), .ada_or(ada_or),
      .adb_d(adb_d), .adb_valid(adb_valid), .adb_or(adb_or),
      .stream(sif),
      .fifo_level(fifo_level), .overflow(overflow),
      .clr_overflow(clr_overflow), .or_count(or_count)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   bit          rawq[$];
   bit          bitq[$];
   int          exp_or = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: rules applied to lists of bits, one call per driven cycle.
   function automatic void model_pair(input bit av, input bit bv, input bit aor, input bit bor, input bit r);
      logic [31:0] w;
      if (!(av && bv)) return;
      if (aor || bor) begin
         if (exp_or < 65535) exp_or++;
         return;
      end
`ifdef RNG_VON_NEUMANN_EN
      rawq.push_back(r);
      if (rawq.size() == 2) begin
         if (rawq[0] != rawq[1]) bitq.push_back(rawq[0]);
         rawq.delete();
      end
`else
      bitq.push_back(r);
`endif
      if (bitq.size() == 32) begin
         w = 32'd0;
         for (int i = 0; i < 32; i++) w[i] = bitq[i];
         exp_q.push_back(w);
         bitq.delete();
      end
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input bit av, input bit bv, input bit aor, input bit bor,
                        input logic [13:0] ad, input logic [13:0] bd);
      ada_valid = av; adb_valid = bv; ada_or = aor; adb_or = bor;
      ada_d = ad; adb_d = bd;
      model_pair(av, bv, aor, bor, ad[0] ^ bd[0]);
      @(posedge clk);
      #1;
      ada_valid = 1'b0; adb_valid = 1'b0; ada_or = 1'b0; adb_or = 1'b0;
   endtask

   task automatic send_raw(input bit b);
      logic [13:0] a, bb;
      a  = 14'($urandom);
      bb = 14'($urandom);
      a[0] = b ^ bb[0];
      drive(1'b1, 1'b1, 1'b0, 1'b0, a, bb);
   endtask

   // One bit at the packer input: a 1,0 / 0,1 raw pair with the corrector, a single raw bit without.
   task automatic send_cbit(input bit b);
`ifdef RNG_VON_NEUMANN_EN
      send_raw(b);
      send_raw(!b);
`else
      send_raw(b);
`endif
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ada_d = 14'($urandom); adb_d = 14'($urandom);
         ada_valid = 1'($urandom); adb_valid = 1'($urandom);
         ada_or = 1'($urandom); adb_or = 1'($urandom);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      ada_valid = 1'b0; adb_valid = 1'b0; ada_or = 1'b0; adb_or = 1'b0;
      exp_q.delete(); rawq.delete(); bitq.delete(); exp_or = 0;
      check("rst_out_data",   sif.out_data, 32'd0);
      check("rst_out_valid",  32'(sif.out_valid), 32'd0);
      check("rst_fifo_level", 32'(fifo_level), 32'd0);
      check("rst_overflow",   32'(overflow), 32'd0);
      check("rst_or_count",   32'(or_count), 32'd0);
   endtask

   task automatic drain();
      idle(LAT + 2);
      sif.out_ready = 1'b1;
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) idle(1);
      check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
      check("drain_level", 32'(fifo_level), 32'd0);
   endtask

   // Monitor: every accepted word must match the head of the expected queue.
   always @(negedge clk) begin
      if (!reset && sif.out_valid && sif.out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL pop_unexpected: got %h required no word at %0t", sif.out_data, $time);
         end else begin
            check("pop_word", sif.out_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit b;
      reset = 1'b1; clr_overflow = 1'b0; sif.out_ready = 1'b0;
      ada_d = 14'd0; adb_d = 14'd0;
      ada_valid = 1'b0; adb_valid = 1'b0; ada_or = 1'b0; adb_or = 1'b0;
      idle(1);
      do_reset();

      // Alternating raw pattern: 0xFFFFFFFF with the corrector, 0x55555555 in bypass; latency check.
      for (int i = 0; i < 32 / (3 - LAT + 1) * (3 - LAT + 1) / 2; i++) begin
         send_raw(1'b1);
         send_raw(1'b0);
      end
`ifdef RNG_VON_NEUMANN_EN
      for (int i = 0; i < 16; i++) begin
         send_raw(1'b1);
         send_raw(1'b0);
      end
`endif
      idle(LAT - 1);
      check("lat_early_valid", 32'(sif.out_valid), 32'd0);
      idle(1);
      check("lat_valid", 32'(sif.out_valid), 32'd1);
      check("lat_level", 32'(fifo_level), 32'd1);
      drain();
      sif.out_ready = 1'b0;

      // Corrector patterns: raw 0,1 repeated, then raw 1,1,0,0 repeated.
      sif.out_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         send_raw(1'b0);
         send_raw(1'b1);
      end
      for (int i = 0; i < 32; i++) begin
         send_raw(1'b1); send_raw(1'b1); send_raw(1'b0); send_raw(1'b0);
      end
      drain();

      // Overrange and single-channel cycles contribute nothing to the partial word.
      do_reset();
      sif.out_ready = 1'b1;
      for (int i = 0; i < 7; i++) send_cbit(1'($urandom));
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 14'($urandom), 14'($urandom));
      for (int i = 0; i < 5; i++)  drive(1'b0, 1'b1, 1'b0, 1'b0, 14'($urandom), 14'($urandom));
      for (int i = 0; i < 3; i++)  drive(1'b1, 1'b0, 1'b1, 1'b0, 14'($urandom), 14'($urandom));
      idle(2);
      check("or_count_10", 32'(or_count), 32'(exp_or));
      for (int i = 0; i < 25; i++) send_cbit(1'($urandom));
      drain();

      // Overflow: DEPTH+1 words with no reader.
      do_reset();
      sif.out_ready = 1'b0;
      for (int i = 0; i < (DEPTH + 1) * 32; i++) send_cbit(1'($urandom));
      void'(exp_q.pop_back());
      idle(LAT + 2);
      check("ovf_level", 32'(fifo_level), 32'(DEPTH));
      check("ovf_set", 32'(overflow), 32'd1);
      clr_overflow = 1'b1;
      idle(1);
      clr_overflow = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);
      // Full FIFO: push and pop in the same cycle.
      for (int i = 0; i < 32; i++) send_cbit(1'($urandom));
      idle(LAT - 1);
      sif.out_ready = 1'b1;
      idle(1);
      sif.out_ready = 1'b0;
      idle(2);
      check("full_pushpop_level", 32'(fifo_level), 32'(DEPTH));
      check("full_pushpop_ovf", 32'(overflow), 32'd0);
      drain();

      // Reset mid-operation: stored word and partial bits are lost.
      sif.out_ready = 1'b0;
      for (int i = 0; i < 52; i++) send_cbit(1'($urandom));
      idle(LAT + 1);
      check("pre_reset_valid", 32'(sif.out_valid), 32'd1);
      do_reset();
      sif.out_ready = 1'b1;
      for (int i = 0; i < 32; i++) send_cbit(1'b1);
      idle(LAT + 1);
      drain();

      // Randomized traffic with a randomly stalling reader.
      for (int i = 0; i < 2500; i++) begin
         sif.out_ready = ($urandom_range(0, 9) < 7);
         b = ($urandom_range(0, 19) == 0);
         drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8), b, ($urandom_range(0, 29) == 0),
               14'($urandom), 14'($urandom));
      end
      drain();
      check("rand_or_count", 32'(or_count), 32'(exp_or));
      check("rand_overflow", 32'(overflow), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
